op_sequencer: RTL and testbench

Parametrised successor to the single-lane op controller. It accepts one LWE operation command (encrypt, decrypt, add or mult) through a valid/ready handshake. It then streams per-beat operand and destination addresses, row indices and lane masks to the datapath, with output backpressure, multi-lane beats and abort. It sits between the host command interface and the ciphertext/key SRAM address ports.

---
 rtl/enclave_pkg.sv | 27 ++
 rtl/beat_counter.sv | 39 +++
 rtl/op_sequencer.sv | 134 +++++++++++++
 tb/tb_op_sequencer.sv | 269 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/enclave_pkg.sv
// Shared definitions for the LWE op sequencer: opcodes, FSM states and
// the beat-count arithmetic derived from the dimension and lane count.
package enclave_pkg;

    localparam logic [1:0] OPCODE_ENCRYPT = 2'b00;
    localparam logic [1:0] OPCODE_DECRYPT = 2'b01;
    localparam logic [1:0] OPCODE_ADD     = 2'b10;
    localparam logic [1:0] OPCODE_MULT    = 2'b11;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'b00,
        ST_RUN_A  = 2'b01,
        ST_RUN_B  = 2'b10,
        ST_FINISH = 2'b11
    } state_t;

    // An operand spans dim+1 words; a sweep issues that many rows in
    // groups of `lanes`, the final group possibly partial.
    function automatic int calc_beats(input int dim, input int lanes);
        return (dim + lanes) / lanes;
    endfunction

    function automatic int calc_rem(input int dim, input int lanes);
        return (dim + 1) % lanes;
    endfunction

endpackage

// File: rtl/beat_counter.sv
// Loadable row counter for one operand sweep: produces the beat's first
// row, the final-beat flag and the lane mask of the beat.
module beat_counter
    import enclave_pkg::*;
#(
    parameter int DIMENSION = 10,
    parameter int LANES     = 1,
    parameter int DIM_WIDTH = $clog2(DIMENSION + 2)
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 load,
    input  logic                 advance,
    output logic [DIM_WIDTH-1:0] row,
    output logic                 last_beat,
    output logic [LANES-1:0]     lane_mask
);

    localparam int BEATS = calc_beats(DIMENSION, LANES);
    localparam int REM   = calc_rem(DIMENSION, LANES);
    localparam logic [DIM_WIDTH-1:0] LAST_ROW  = DIM_WIDTH'((BEATS - 1) * LANES);
    localparam logic [LANES-1:0]     TAIL_MASK = (REM == 0) ? '1 : LANES'((1 << REM) - 1);

    // NOTE: state registers use non-blocking assignments so every flop
    // samples the pre-edge value regardless of block ordering.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            row <= '0;
        end else if (load) begin
            row <= '0;
        end else if (advance) begin
            row <= row + DIM_WIDTH'(LANES);
        end
    end

    assign last_beat = (row == LAST_ROW);
    assign lane_mask = last_beat ? TAIL_MASK : '1;

endmodule

// File: rtl/op_sequencer.sv
// LWE operation sequencer: accepts one command and streams per-beat SRAM
// addresses, row indices and lane masks to the datapath.
module op_sequencer
    import enclave_pkg::*;
#(
    parameter int ADDR_WIDTH = 16,
    parameter int DIMENSION  = 10,
    parameter int LANES      = 1,
    parameter int DIM_WIDTH  = $clog2(DIMENSION + 2)
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  cmd_valid,
    output logic                  cmd_ready,
    input  logic [1:0]            cmd_opcode,
    input  logic [ADDR_WIDTH-1:0] cmd_op1_base,
    input  logic [ADDR_WIDTH-1:0] cmd_op2_base,
    input  logic [ADDR_WIDTH-1:0] cmd_dst_base,
    input  logic                  abort,
    output logic                  beat_valid,
    input  logic                  beat_ready,
    output logic [1:0]            opcode_out,
    output logic [ADDR_WIDTH-1:0] op1_addr,
    output logic [ADDR_WIDTH-1:0] op2_addr,
    output logic [ADDR_WIDTH-1:0] dst_addr,
    output logic                  op_select,
    output logic [DIM_WIDTH-1:0]  row,
    output logic [LANES-1:0]      lane_mask,
    output logic                  last,
    output logic                  busy,
    output logic                  done
);

    localparam logic [ADDR_WIDTH-1:0] ADDR_STEP = ADDR_WIDTH'(LANES);

    state_t state, next_state;
    logic   cmd_take, accept, cnt_load, last_beat;
    logic [LANES-1:0] cnt_mask;

    beat_counter #(
        .DIMENSION (DIMENSION),
        .LANES     (LANES),
        .DIM_WIDTH (DIM_WIDTH)
    ) u_beat_counter (
        .clk       (clk),
        .rst_n     (rst_n),
        .load      (cnt_load),
        .advance   (accept),
        .row       (row),
        .last_beat (last_beat),
        .lane_mask (cnt_mask)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= ST_IDLE;
        end else begin
            state <= next_state;
        end
    end

    // NOTE: every always_comb output gets a default first so no path
    // leaves a signal unassigned and infers a latch.
    always_comb begin
        next_state = state;
        cmd_ready  = 1'b0;
        beat_valid = 1'b0;
        busy       = 1'b0;
        done       = 1'b0;
        op_select  = 1'b0;
        last       = 1'b0;
        cmd_take   = 1'b0;
        accept     = 1'b0;
        cnt_load   = 1'b0;

        unique case (state)
            ST_IDLE: begin
                cmd_ready = 1'b1;
                cmd_take  = cmd_valid;
                cnt_load  = cmd_valid;
                if (cmd_valid) next_state = ST_RUN_A;
            end
            ST_RUN_A, ST_RUN_B: begin
                beat_valid = 1'b1;
                busy       = 1'b1;
                op_select  = (state == ST_RUN_B);
                last       = last_beat && ((state == ST_RUN_B) || (opcode_out != OPCODE_MULT));
                // Abort outranks the handshake: the presented beat is dropped.
                accept     = beat_ready && !abort;
                if (abort) begin
                    cnt_load   = 1'b1;
                    next_state = ST_IDLE;
                end else if (accept && last_beat) begin
                    cnt_load   = 1'b1;
                    next_state = last ? ST_FINISH : ST_RUN_B;
                end
            end
            ST_FINISH: begin
                done       = 1'b1;
                next_state = ST_IDLE;
            end
            default: next_state = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            opcode_out <= OPCODE_ENCRYPT;
            op1_addr   <= '0;
            op2_addr   <= '0;
            dst_addr   <= '0;
        end else if (cmd_take) begin
            opcode_out <= cmd_opcode;
            op1_addr   <= cmd_op1_base;
            op2_addr   <= cmd_op2_base;
            dst_addr   <= cmd_dst_base;
        end else if (accept) begin
            // MULT sweeps op1 alone, then op2 and dst together.
            if (state == ST_RUN_B) begin
                op2_addr <= op2_addr + ADDR_STEP;
                dst_addr <= dst_addr + ADDR_STEP;
            end else if (opcode_out == OPCODE_MULT) begin
                op1_addr <= op1_addr + ADDR_STEP;
            end else begin
                op1_addr <= op1_addr + ADDR_STEP;
                op2_addr <= op2_addr + ADDR_STEP;
                dst_addr <= dst_addr + ADDR_STEP;
            end
        end
    end

    assign lane_mask = beat_valid ? cnt_mask : '0;

endmodule

// File: tb/tb_op_sequencer.sv
// Self-checking bench for op_sequencer: a LANES=1 and a LANES=4 instance
// checked beat-by-beat against a list of expected beats built from the rules.
module tb_op_sequencer;

    localparam int DIM = 10;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        sel;
    logic        cmd_valid;
    logic [1:0]  cmd_opcode;
    logic [15:0] cmd_op1_base, cmd_op2_base, cmd_dst_base;
    logic        abort, beat_ready;

    logic        cv1, cr1, bv1, os1, la1, bu1, dn1;
    logic        cv4, cr4, bv4, os4, la4, bu4, dn4;
    logic [1:0]  oc1, oc4;
    logic [15:0] a1_1, a2_1, ad_1, a1_4, a2_4, ad_4;
    logic [3:0]  rw1, rw4;
    logic [0:0]  lm1;
    logic [3:0]  lm4;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic [15:0] op1, op2, dst;
        logic [3:0]  row;
        logic [3:0]  mask;
        logic        opsel;
        logic        last;
    } exp_beat_t;

    exp_beat_t exp_q[$];

    always #5 clk = ~clk;

    assign cv1 = cmd_valid && !sel;
    assign cv4 = cmd_valid && sel;

    op_sequencer #(.ADDR_WIDTH(16), .DIMENSION(DIM), .LANES(1)) dut1 (
        .clk(clk), .rst_n(rst_n), .cmd_valid(cv1), .cmd_ready(cr1),
        .cmd_opcode(cmd_opcode), .cmd_op1_base(cmd_op1_base),
        .cmd_op2_base(cmd_op2_base), .cmd_dst_base(cmd_dst_base),
        .abort(abort), .beat_valid(bv1), .beat_ready(beat_ready),
        .opcode_out(oc1), .op1_addr(a1_1), .op2_addr(a2_1), .dst_addr(ad_1),
        .op_select(os1), .row(rw1), .lane_mask(lm1), .last(la1),
        .busy(bu1), .done(dn1)
    );

    op_sequencer #(.ADDR_WIDTH(16), .DIMENSION(DIM), .LANES(4)) dut4 (
        .clk(clk), .rst_n(rst_n), .cmd_valid(cv4), .cmd_ready(cr4),
        .cmd_opcode(cmd_opcode), .cmd_op1_base(cmd_op1_base),
        .cmd_op2_base(cmd_op2_base), .cmd_dst_base(cmd_dst_base),
        .abort(abort), .beat_valid(bv4), .beat_ready(beat_ready),
        .opcode_out(oc4), .op1_addr(a1_4), .op2_addr(a2_4), .dst_addr(ad_4),
        .op_select(os4), .row(rw4), .lane_mask(lm4), .last(la4),
        .busy(bu4), .done(dn4)
    );

    // Observed view of whichever instance is selected.
    wire        o_cr  = sel ? cr4 : cr1;
    wire        o_bv  = sel ? bv4 : bv1;
    wire        o_os  = sel ? os4 : os1;
    wire        o_la  = sel ? la4 : la1;
    wire        o_bu  = sel ? bu4 : bu1;
    wire        o_dn  = sel ? dn4 : dn1;
    wire [1:0]  o_oc  = sel ? oc4 : oc1;
    wire [15:0] o_a1  = sel ? a1_4 : a1_1;
    wire [15:0] o_a2  = sel ? a2_4 : a2_1;
    wire [15:0] o_ad  = sel ? ad_4 : ad_1;
    wire [3:0]  o_rw  = sel ? rw4 : rw1;
    wire [3:0]  o_lm  = sel ? lm4 : {3'b000, lm1};

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_cmd_ready"}, o_cr, 1);
        check({tag, "_beat_valid"}, o_bv, 0);
        check({tag, "_busy"}, o_bu, 0);
        check({tag, "_done"}, o_dn, 0);
        check({tag, "_last"}, o_la, 0);
        check({tag, "_op_select"}, o_os, 0);
        check({tag, "_row"}, o_rw, 0);
        check({tag, "_lane_mask"}, o_lm, 0);
        check({tag, "_opcode"}, o_oc, 0);
        check({tag, "_op1"}, o_a1, 0);
        check({tag, "_op2"}, o_a2, 0);
        check({tag, "_dst"}, o_ad, 0);
    endtask

    // Expected beat list straight from the sweep rules.
    task automatic build_expect(input logic [1:0] op, input logic [15:0] b1, b2, b3,
                                input int lanes);
        int beats  = (DIM + 1 + lanes - 1) / lanes;
        int rem    = (DIM + 1) % lanes;
        int sweeps = (op == 2'b11) ? 2 : 1;
        exp_beat_t e;
        exp_q.delete();
        for (int s = 0; s < sweeps; s++) begin
            for (int k = 0; k < beats; k++) begin
                int r = k * lanes;
                e.row   = 4'(r);
                e.mask  = (k == beats - 1 && rem != 0) ? 4'((1 << rem) - 1) : 4'((1 << lanes) - 1);
                e.opsel = (s == 1);
                e.last  = (s == sweeps - 1) && (k == beats - 1);
                if (sweeps == 1) begin
                    e.op1 = 16'(b1 + r);
                    e.op2 = 16'(b2 + r);
                    e.dst = 16'(b3 + r);
                end else if (s == 0) begin
                    e.op1 = 16'(b1 + r);
                    e.op2 = b2;
                    e.dst = b3;
                end else begin
                    e.op1 = 16'(b1 + beats * lanes);
                    e.op2 = 16'(b2 + r);
                    e.dst = 16'(b3 + r);
                end
                exp_q.push_back(e);
            end
        end
    endtask

    // mode: 0 ready high, 1 ready pattern 1,0,0,1, 2 random ready.
    // abort_at / reset_at: accepted-beat index at which to abort / reset (-1 none).
    // hold: keep cmd_valid high with other bases while busy.
    task automatic do_cmd(input bit s, input logic [1:0] op, input logic [15:0] b1, b2, b3,
                          input int mode, input int abort_at, input int reset_at, input bit hold);
        int n_acc = 0;
        int cyc   = 0;
        bit br, ab;
        exp_beat_t e;
        build_expect(op, b1, b2, b3, s ? 4 : 1);
        sel = s;
        #1;
        check("cmd_ready_before_cmd", o_cr, 1);
        cmd_valid    = 1'b1;
        cmd_opcode   = op;
        cmd_op1_base = b1;
        cmd_op2_base = b2;
        cmd_dst_base = b3;
        @(posedge clk); #1;
        if (hold) begin
            cmd_opcode   = ~op;
            cmd_op1_base = 16'($urandom);
            cmd_op2_base = 16'($urandom);
            cmd_dst_base = 16'($urandom);
        end else begin
            cmd_valid = 1'b0;
        end
        while (exp_q.size() > 0) begin
            if (cyc >= 400) begin
                check("beat_timeout_remaining", exp_q.size(), 0);
                break;
            end
            br = (mode == 0) ? 1'b1 : (mode == 1) ? ((cyc % 4 == 0) || (cyc % 4 == 3)) : 1'($urandom);
            ab = (n_acc == abort_at);
            beat_ready = br;
            abort      = ab;
            if (n_acc == reset_at) begin
                rst_n = 1'b0;
                #1;
                check_reset_outputs("mid_reset");
                cmd_valid  = 1'b0;
                abort      = 1'b0;
                beat_ready = 1'b0;
                #1;
                rst_n = 1'b1;
                @(posedge clk); #1;
                check_reset_outputs("after_reset");
                return;
            end
            @(negedge clk);
            e = exp_q[0];
            check("beat_valid", o_bv, 1);
            check("busy", o_bu, 1);
            check("cmd_ready_busy", o_cr, 0);
            check("done_during_run", o_dn, 0);
            check("opcode_out", o_oc, op);
            check("op1_addr", o_a1, e.op1);
            check("op2_addr", o_a2, e.op2);
            check("dst_addr", o_ad, e.dst);
            check("row", o_rw, e.row);
            check("lane_mask", o_lm, e.mask);
            check("op_select", o_os, e.opsel);
            check("last", o_la, e.last);
            @(posedge clk); #1;
            cyc++;
            if (ab) begin
                abort      = 1'b0;
                beat_ready = 1'b0;
                check("abort_beat_valid", o_bv, 0);
                check("abort_busy", o_bu, 0);
                check("abort_no_done", o_dn, 0);
                check("abort_cmd_ready", o_cr, 1);
                return;
            end
            if (br) begin
                void'(exp_q.pop_front());
                n_acc++;
            end
        end
        cmd_valid  = 1'b0;
        beat_ready = 1'b0;
        check("finish_done", o_dn, 1);
        check("finish_beat_valid", o_bv, 0);
        check("finish_cmd_ready", o_cr, 0);
        @(posedge clk); #1;
        check("idle_done_clear", o_dn, 0);
        check("idle_cmd_ready", o_cr, 1);
    endtask

    initial begin
        rst_n        = 1'b0;
        sel          = 1'b0;
        cmd_valid    = 1'b0;
        cmd_opcode   = 2'b00;
        cmd_op1_base = '0;
        cmd_op2_base = '0;
        cmd_dst_base = '0;
        abort        = 1'b0;
        beat_ready   = 1'b0;
        #2;
        check_reset_outputs("reset_l1");
        sel = 1'b1;
        #1;
        check_reset_outputs("reset_l4");
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(posedge clk); #1;

        // ENCRYPT, one lane, ready held high
        do_cmd(1'b0, 2'b00, 16'h0020, 16'h0040, 16'h0080, 0, -1, -1, 1'b0);
        // ADD, four lanes: partial final beat
        do_cmd(1'b1, 2'b10, 16'h0020, 16'h0040, 16'h0080, 0, -1, -1, 1'b0);
        // MULT, one lane: two sweeps
        do_cmd(1'b0, 2'b11, 16'h0000, 16'h0100, 16'h0200, 0, -1, -1, 1'b0);
        // ENCRYPT with ready pattern 1,0,0,1
        do_cmd(1'b0, 2'b00, 16'h0020, 16'h0040, 16'h0080, 1, -1, -1, 1'b0);
        // Abort on the 5th beat, then a fresh command
        do_cmd(1'b0, 2'b00, 16'h0020, 16'h0040, 16'h0080, 0, 4, -1, 1'b0);
        do_cmd(1'b0, 2'b01, 16'h0300, 16'h0310, 16'h0320, 0, -1, -1, 1'b0);
        // MULT across the address wrap with four lanes and random ready
        do_cmd(1'b1, 2'b11, 16'hFFFC, 16'hFFF8, 16'hFFFE, 2, -1, -1, 1'b0);
        // Abort during the second MULT sweep
        do_cmd(1'b1, 2'b11, 16'h1000, 16'h2000, 16'h3000, 2, 4, -1, 1'b0);

        for (int i = 0; i < 8; i++) begin
            do_cmd(1'($urandom), 2'($urandom), 16'($urandom), 16'($urandom), 16'($urandom),
                   2, -1, -1, 1'b0);
        end

        // cmd_valid held while busy, then reset pulsed mid-MULT
        do_cmd(1'b0, 2'b11, 16'h0000, 16'h0100, 16'h0200, 1, -1, 14, 1'b1);
        do_cmd(1'b0, 2'b10, 16'h0500, 16'h0600, 16'h0700, 0, -1, -1, 1'b0);
        do_cmd(1'b1, 2'b01, 16'h0050, 16'h0060, 16'h0070, 2, -1, -1, 1'b1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
